flit_route_ctrl: RTL and testbench

- Sits directly downstream of the input datapath in each router input port.
- Takes the single arbitrated flit stream, with its VC id already stamped, and decodes the flit type.
- Computes the XY output direction for head flits and locks that direction per VC until the tail flit (wormhole).
- Presents the flit plus a one-hot direction to the switch allocator through one registered valid/ready stage.

---
 rtl/noc_pkg.sv | 39 +++
 rtl/flit_route_ctrl_if.sv | 35 +++
 rtl/xy_route_calc.sv | 34 +++
 rtl/flit_route_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_flit_route_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router input-port route controller.
// Holds the flit layout offsets, flit type and lock state encodings and the
// one-hot output direction constants.
package noc_pkg;

  localparam int FLIT_W        = 37;
  localparam int FLIT_VALID    = 0;
  localparam int FLIT_VC_LSB   = 1;
  localparam int FLIT_DATA_LSB = 3;
  localparam int VC_W          = 2;
  localparam int DATA_W        = FLIT_W - FLIT_DATA_LSB;
  // Offsets below are relative to fdata (fin_req_i[36:3]).
  localparam int TYPE_MSB      = 33;
  localparam int DEST_MSB      = 31;
  localparam int DIR_BITS      = 5;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [DIR_BITS-1:0] DIR_N = 5'b00001;
  localparam logic [DIR_BITS-1:0] DIR_S = 5'b00010;
  localparam logic [DIR_BITS-1:0] DIR_E = 5'b00100;
  localparam logic [DIR_BITS-1:0] DIR_W = 5'b01000;
  localparam logic [DIR_BITS-1:0] DIR_L = 5'b10000;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_DATA_LSB+TYPE_MSB -: 2]);
  endfunction

endpackage

// File: rtl/flit_route_ctrl_if.sv
// Flit link bundle between the input datapath, the route controller and the
// switch allocator.
//   fin_req_i   : flit from input datapath ([0] valid, [2:1] vc, [36:3] data)
//   fin_resp_o  : ready back to input datapath
//   fout_req_o  : registered flit towards the switch allocator
//   fout_dir_o  : one-hot output direction (N,S,E,W,L)
//   fout_resp_i : ready from the switch allocator
// master = environment side (drives requests in, ready from switch),
// slave  = route controller side.
interface flit_route_ctrl_if;
  import noc_pkg::*;

  logic [FLIT_W-1:0]   fin_req_i;
  logic                fin_resp_o;
  logic [FLIT_W-1:0]   fout_req_o;
  logic [DIR_BITS-1:0] fout_dir_o;
  logic                fout_resp_i;

  modport master (
    output fin_req_i,
    output fout_resp_i,
    input  fin_resp_o,
    input  fout_req_o,
    input  fout_dir_o
  );

  modport slave (
    input  fin_req_i,
    input  fout_resp_i,
    output fin_resp_o,
    output fout_req_o,
    output fout_dir_o
  );

endinterface

// File: rtl/xy_route_calc.sv
// Combinational XY (dimension-ordered) route computation.
//   x_dest_i, y_dest_i : destination coordinates from the head flit
//   dir_o              : one-hot output direction (N,S,E,W,L)
// X is resolved first; Y only when X already matches. Comparisons unsigned.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int ROUTER_X = 1,
  parameter int ROUTER_Y = 1,
  parameter int X_W      = 2,
  parameter int Y_W      = 2
) (
  input  logic [X_W-1:0]      x_dest_i,
  input  logic [Y_W-1:0]      y_dest_i,
  output logic [DIR_BITS-1:0] dir_o
);

  localparam logic [X_W-1:0] MY_X = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] MY_Y = Y_W'(ROUTER_Y);

  always_comb begin
    dir_o = DIR_L;
    if (x_dest_i > MY_X) begin
      dir_o = DIR_E;
    end else if (x_dest_i < MY_X) begin
      dir_o = DIR_W;
    end else if (y_dest_i > MY_Y) begin
      dir_o = DIR_S;
    end else if (y_dest_i < MY_Y) begin
      dir_o = DIR_N;
    end
  end

endmodule

// File: rtl/flit_route_ctrl.sv
// Router input-port route controller.
// Decodes the flit type, computes the XY direction for head flits, holds that
// direction per VC until the tail (wormhole lock), and presents flit plus
// one-hot direction to the switch allocator through one registered
// valid/ready stage.
//   clk   : core clock
//   arst  : synchronous active-high reset
//   fio   : flit link (input side, output side, direction)
//   err_o : one-cycle protocol-error pulse (bad VC, orphan body/tail,
//           head while locked)
//
// Per-VC lock FSM:
//   state    | meaning
//   UNLOCKED | no packet in flight on this VC; only HEAD/HEAD_TAIL legal
//   LOCKED   | packet in flight; BODY/TAIL follow dir_q of that VC
module flit_route_ctrl
  import noc_pkg::*;
#(
  parameter int ROUTER_X = 1,
  parameter int ROUTER_Y = 1,
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter int N_VC     = 3
) (
  input  logic              clk,
  input  logic              arst,
  flit_route_ctrl_if.slave  fio,
  output logic              err_o
);

  logic [FLIT_W-1:0]   out_req_q, out_req_d;
  logic [DIR_BITS-1:0] out_dir_q, out_dir_d;
  logic                err_q, err_d;
  lock_state_e         lock_q [N_VC];
  lock_state_e         lock_d [N_VC];
  logic [DIR_BITS-1:0] dir_q  [N_VC];
  logic [DIR_BITS-1:0] dir_d  [N_VC];

  logic                out_valid;
  logic                rdy;
  logic                acc;
  logic                drn;
  logic [VC_W-1:0]     vc;
  logic                vc_ok;
  flit_type_e          ftype;
  logic [X_W-1:0]      x_dest;
  logic [Y_W-1:0]      y_dest;
  logic [DIR_BITS-1:0] route_dir;

  lock_state_e         cur_lock, new_lock;
  logic [DIR_BITS-1:0] cur_dir, new_dir;
  logic                fwd;
  logic [DIR_BITS-1:0] fwd_dir;

  assign out_valid = out_req_q[FLIT_VALID];
  // Ready looks at the downstream ready combinationally so a draining output
  // register can be refilled in the same cycle (no bubble).
  assign rdy       = !arst && (!out_valid || fio.fout_resp_i);
  assign acc       = fio.fin_req_i[FLIT_VALID] && rdy;
  assign drn       = out_valid && fio.fout_resp_i;

  assign vc     = fio.fin_req_i[FLIT_VC_LSB +: VC_W];
  assign vc_ok  = 32'(vc) < N_VC;
  assign ftype  = flit_type(fio.fin_req_i);
  assign x_dest = fio.fin_req_i[FLIT_DATA_LSB+DEST_MSB -: X_W];
  assign y_dest = fio.fin_req_i[FLIT_DATA_LSB+DEST_MSB-X_W -: Y_W];

  xy_route_calc #(
    .ROUTER_X (ROUTER_X),
    .ROUTER_Y (ROUTER_Y),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_xy_route_calc (
    .x_dest_i (x_dest),
    .y_dest_i (y_dest),
    .dir_o    (route_dir)
  );

  // Lock FSM next state and forwarding decision for the accepted flit.
  always_comb begin
    lock_d   = lock_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    fwd      = 1'b0;
    fwd_dir  = '0;
    cur_lock = UNLOCKED;
    cur_dir  = '0;
    new_lock = UNLOCKED;
    new_dir  = '0;

    for (int v = 0; v < N_VC; v++) begin
      if (32'(vc) == v) begin
        cur_lock = lock_q[v];
        cur_dir  = dir_q[v];
      end
    end
    new_lock = cur_lock;
    new_dir  = cur_dir;

    if (acc) begin
      if (!vc_ok) begin
        // Out-of-range VC: swallow the flit, touch no lock.
        err_d = 1'b1;
      end else begin
        case (ftype)
          HEAD: begin
            err_d    = (cur_lock == LOCKED);
            new_lock = LOCKED;
            new_dir  = route_dir;
            fwd      = 1'b1;
            fwd_dir  = route_dir;
          end
          HEAD_TAIL: begin
            err_d    = (cur_lock == LOCKED);
            new_lock = UNLOCKED;
            fwd      = 1'b1;
            fwd_dir  = route_dir;
          end
          default: begin
            if (cur_lock == LOCKED) begin
              fwd     = 1'b1;
              fwd_dir = cur_dir;
              if (ftype == TAIL) begin
                new_lock = UNLOCKED;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        endcase

        for (int v = 0; v < N_VC; v++) begin
          if (32'(vc) == v) begin
            lock_d[v] = new_lock;
            dir_d[v]  = new_dir;
          end
        end
      end
    end
  end

  // Output stage: a forwarded accept reloads; a drain with nothing new clears.
  // Dropped flits never reach the register.
  always_comb begin
    out_req_d = out_req_q;
    out_dir_d = out_dir_q;
    if (acc && fwd) begin
      out_req_d = fio.fin_req_i;
      out_dir_d = fwd_dir;
    end else if (drn) begin
      out_req_d = '0;
      out_dir_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      out_req_q <= '0;
      out_dir_q <= '0;
      err_q     <= 1'b0;
      for (int v = 0; v < N_VC; v++) begin
        lock_q[v] <= UNLOCKED;
        dir_q[v]  <= '0;
      end
    end else begin
      out_req_q <= out_req_d;
      out_dir_q <= out_dir_d;
      err_q     <= err_d;
      for (int v = 0; v < N_VC; v++) begin
        lock_q[v] <= lock_d[v];
        dir_q[v]  <= dir_d[v];
      end
    end
  end

  assign fio.fin_resp_o = rdy;
  assign fio.fout_req_o = out_req_q;
  assign fio.fout_dir_o = out_dir_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_flit_route_ctrl.sv
module tb_flit_route_ctrl;

  logic clk;
  logic arst;
  logic err_o;

  flit_route_ctrl_if u_if ();

  flit_route_ctrl #(
    .ROUTER_X (1),
    .ROUTER_Y (1),
    .X_W      (2),
    .Y_W      (2),
    .N_VC     (3)
  ) dut (
    .clk   (clk),
    .arst  (arst),
    .fio   (u_if),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: packet-level view of the port.
  bit          m_locked [4];
  logic [4:0]  m_ldir   [4];
  logic [36:0] m_req;
  logic [4:0]  m_dir;
  logic        m_err;
  logic        exp_rdy;
  logic        obs_rdy;

  function automatic logic [36:0] mk(input logic [1:0] t, input logic [1:0] x,
                                     input logic [1:0] y, input logic [1:0] vc);
    logic [27:0] p;
    p = 28'($urandom);
    return {t, x, y, p, vc, 1'b1};
  endfunction

  function automatic logic [4:0] xy_route(input int x, input int y);
    if (x > 1) return 5'b00100;
    if (x < 1) return 5'b01000;
    if (y > 1) return 5'b00010;
    if (y < 1) return 5'b00001;
    return 5'b10000;
  endfunction

  // One clock: drive at negedge, sample ready before the edge, advance the
  // model at the edge, leave outputs settled 1 time unit after it.
  task automatic step(input logic [36:0] req, input logic resp, input logic rst);
    int vc, x, y, t;
    bit acc, fwd;
    logic [4:0] d;
    @(negedge clk);
    u_if.fin_req_i   = req;
    u_if.fout_resp_i = resp;
    arst             = rst;
    #1;
    obs_rdy = u_if.fin_resp_o;
    exp_rdy = !rst && (!m_req[0] || resp);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_locked[i] = 0;
        m_ldir[i]   = '0;
      end
      m_req = '0;
      m_dir = '0;
      m_err = 1'b0;
    end else begin
      acc   = req[0] && exp_rdy;
      fwd   = 0;
      d     = '0;
      m_err = 1'b0;
      if (acc) begin
        vc = int'(req[2:1]);
        t  = int'(req[36:35]);
        x  = int'(req[34:33]);
        y  = int'(req[32:31]);
        if (vc >= 3) begin
          m_err = 1'b1;
        end else if (t == 0 || t == 3) begin
          m_err = m_locked[vc];
          d = xy_route(x, y);
          fwd = 1;
          m_locked[vc] = (t == 0);
          if (t == 0) m_ldir[vc] = d;
        end else if (!m_locked[vc]) begin
          m_err = 1'b1;
        end else begin
          d = m_ldir[vc];
          fwd = 1;
          if (t == 2) m_locked[vc] = 0;
        end
      end
      if (fwd) begin
        m_req = req;
        m_dir = d;
      end else if (m_req[0] && resp) begin
        m_req = '0;
        m_dir = '0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(mk(2'b00, 2'd2, 2'd1, 2'd0), 1'b1, 1'b1);
      n_checks++;
      if (obs_rdy !== 1'b0) $display("FAIL reset_rdy_low got=%b want=0", obs_rdy);
      else n_pass++;
    end
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (obs_rdy !== 1'b1) $display("FAIL reset_rdy_high got=%b want=1", obs_rdy);
    else n_pass++;
    n_checks++;
    if (u_if.fout_req_o !== 37'd0 || u_if.fout_dir_o !== 5'd0 || err_o !== 1'b0)
      $display("FAIL reset_outputs got req=%h dir=%b err=%b want 0/0/0", u_if.fout_req_o, u_if.fout_dir_o, err_o);
    else n_pass++;
  endtask

  task automatic test_head_tail();
    logic [36:0] f;
    f = mk(2'b00, 2'd2, 2'd1, 2'd1);
    step(f, 1'b1, 1'b0);
    n_checks++;
    if (u_if.fout_req_o !== f || u_if.fout_dir_o !== 5'b00100)
      $display("FAIL head_east got req=%h dir=%b want req=%h dir=00100", u_if.fout_req_o, u_if.fout_dir_o, f);
    else n_pass++;
    f = mk(2'b10, 2'd0, 2'd0, 2'd1);
    step(f, 1'b1, 1'b0);
    n_checks++;
    if (u_if.fout_req_o !== f || u_if.fout_dir_o !== 5'b00100 || err_o !== 1'b0)
      $display("FAIL tail_east got req=%h dir=%b err=%b want req=%h dir=00100 err=0", u_if.fout_req_o, u_if.fout_dir_o, err_o, f);
    else n_pass++;
    // VC1 must be unlocked again: an orphan BODY is dropped with an error.
    step(mk(2'b01, 2'd0, 2'd0, 2'd1), 1'b1, 1'b0);
    n_checks++;
    if (err_o !== 1'b1 || u_if.fout_req_o[0] !== 1'b0)
      $display("FAIL vc1_unlocked got err=%b valid=%b want err=1 valid=0", err_o, u_if.fout_req_o[0]);
    else n_pass++;
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_head_tail_single();
    logic [36:0] f;
    f = mk(2'b11, 2'd1, 2'd1, 2'd0);
    step(f, 1'b1, 1'b0);
    n_checks++;
    if (u_if.fout_req_o !== f || u_if.fout_dir_o !== 5'b10000 || err_o !== 1'b0)
      $display("FAIL ht_local got req=%h dir=%b err=%b want req=%h dir=10000 err=0", u_if.fout_req_o, u_if.fout_dir_o, err_o, f);
    else n_pass++;
    step(mk(2'b01, 2'd3, 2'd3, 2'd0), 1'b1, 1'b0);
    n_checks++;
    if (err_o !== 1'b1 || u_if.fout_req_o !== 37'd0)
      $display("FAIL ht_orphan_body got err=%b req=%h want err=1 req=0", err_o, u_if.fout_req_o);
    else n_pass++;
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL err_one_cycle got=%b want=0", err_o);
    else n_pass++;
  endtask

  task automatic test_interleave();
    logic [36:0] f;
    logic [4:0]  want [4];
    logic [36:0] fl   [4];
    fl[0] = mk(2'b00, 2'd0, 2'd3, 2'd0);
    fl[1] = mk(2'b00, 2'd1, 2'd0, 2'd2);
    fl[2] = mk(2'b01, 2'd3, 2'd3, 2'd0);
    fl[3] = mk(2'b10, 2'd2, 2'd2, 2'd2);
    want[0] = 5'b01000; want[1] = 5'b00001; want[2] = 5'b01000; want[3] = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      f = fl[i];
      step(f, 1'b1, 1'b0);
      n_checks++;
      if (u_if.fout_req_o !== f || u_if.fout_dir_o !== want[i] || err_o !== 1'b0)
        $display("FAIL interleave_%0d got req=%h dir=%b err=%b want req=%h dir=%b err=0", i, u_if.fout_req_o, u_if.fout_dir_o, err_o, f, want[i]);
      else n_pass++;
    end
    step(mk(2'b10, 2'd0, 2'd0, 2'd0), 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [36:0] h, b;
    h = mk(2'b00, 2'd2, 2'd2, 2'd0);
    b = mk(2'b01, 2'd0, 2'd0, 2'd0);
    step(h, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(b, 1'b0, 1'b0);
      n_checks++;
      if (obs_rdy !== 1'b0 || u_if.fout_req_o !== h || u_if.fout_dir_o !== 5'b00100)
        $display("FAIL bp_hold_%0d got rdy=%b req=%h dir=%b want rdy=0 req=%h dir=00100", i, obs_rdy, u_if.fout_req_o, u_if.fout_dir_o, h);
      else n_pass++;
    end
    step(b, 1'b1, 1'b0);
    n_checks++;
    if (obs_rdy !== 1'b1 || u_if.fout_req_o !== b || u_if.fout_dir_o !== 5'b00100)
      $display("FAIL bp_no_bubble got rdy=%b req=%h dir=%b want rdy=1 req=%h dir=00100", obs_rdy, u_if.fout_req_o, u_if.fout_dir_o, b);
    else n_pass++;
    step(mk(2'b10, 2'd0, 2'd0, 2'd0), 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_errors();
    step(mk(2'b00, 2'd2, 2'd1, 2'd3), 1'b1, 1'b0);
    n_checks++;
    if (obs_rdy !== 1'b1 || err_o !== 1'b1 || u_if.fout_req_o !== 37'd0)
      $display("FAIL bad_vc got rdy=%b err=%b req=%h want rdy=1 err=1 req=0", obs_rdy, err_o, u_if.fout_req_o);
    else n_pass++;
    step(mk(2'b00, 2'd0, 2'd0, 2'd1), 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    step(mk(2'b01, 2'd0, 2'd0, 2'd1), 1'b1, 1'b0);
    n_checks++;
    if (err_o !== 1'b1 || u_if.fout_req_o !== 37'd0)
      $display("FAIL reset_mid_packet got err=%b req=%h want err=1 req=0", err_o, u_if.fout_req_o);
    else n_pass++;
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [36:0] f;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) f = '0;
      else f = mk(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom_range(0, 3)));
      step(f, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      n_checks++;
      if (obs_rdy !== exp_rdy || u_if.fout_req_o !== m_req || u_if.fout_dir_o !== m_dir || err_o !== m_err) begin
        if (bad < 10)
          $display("FAIL random_%0d got rdy=%b req=%h dir=%b err=%b want rdy=%b req=%h dir=%b err=%b", i, obs_rdy, u_if.fout_req_o, u_if.fout_dir_o, err_o, exp_rdy, m_req, m_dir, m_err);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    arst             = 1'b1;
    u_if.fin_req_i   = '0;
    u_if.fout_resp_i = 1'b0;
    m_req            = '0;
    m_dir            = '0;
    m_err            = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_locked[i] = 0;
      m_ldir[i]   = '0;
    end
    test_reset();
    test_head_tail();
    test_head_tail_single();
    test_interleave();
    test_backpressure();
    test_errors();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
